block_sync_supervisor: RTL and testbench
========================================

BLOCK_SYNC_SUPERVISOR -- requirements
Module: block_sync_supervisor

Interface
REQ-001 SHALL have parameter N_LANES, default 20, number of PCS lanes supervised.
REQ-002 SHALL have parameter NB_TIMER, default 16, width of acquire/stable timers.
REQ-003 SHALL have parameter NB_STAT, default 8, width of statistics counters.
REQ-004 SHALL have i_clock  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have i_reset  in  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have i_enable  in  1  supervisor run enable.
REQ-007 SHALL have i_signal_ok  in  1  PMA signal indication.
REQ-008 SHALL have i_block_lock  in  N_LANES  per-lane block lock from block sync instances.
REQ-009 SHALL have i_acquire_limit  in  NB_TIMER  cycles allowed to reach all-lane lock.
REQ-010 SHALL have i_stable_limit  in  NB_TIMER  cycles all lanes must stay locked before declaring lock.
REQ-011 SHALL have o_lane_enable  out  N_LANES  per-lane enable to block sync instances.
REQ-012 SHALL have o_lane_restart  out  N_LANES  one-cycle per-lane resync pulse.
REQ-013 SHALL have o_all_locked  out  1  all lanes locked and stable.
REQ-014 SHALL have o_state  out  2  current FSM state encoding.
REQ-015 SHALL have o_loss_cnt, o_restart_cnt  out  NB_STAT each  saturating statistics.

Function
REQ-016 FSM states SHALL be IDLE=0, ACQUIRE=1, STABLE=2, LOCKED=3, registered, o_state = state.
REQ-017 From any state, i_enable=0 or i_signal_ok=0 SHALL force IDLE next cycle; this has priority over every other transition.
REQ-018 IDLE: o_lane_enable=0, timer=0; with i_enable=1 and i_signal_ok=1 SHALL go to ACQUIRE.
REQ-019 ACQUIRE/STABLE/LOCKED: o_lane_enable = all ones.
REQ-020 ACQUIRE: timer increments each cycle; &i_block_lock=1 SHALL go to STABLE, timer cleared.
REQ-021 ACQUIRE: timer == i_acquire_limit with lock incomplete SHALL pulse o_lane_restart[k]=1 for exactly one cycle for every lane k with i_block_lock[k]=0, clear timer, increment o_restart_cnt, remain in ACQUIRE.
REQ-022 Lock completion and timeout in the same cycle: lock completion SHALL win, no restart pulse.
REQ-023 STABLE: timer increments; any lane unlocked SHALL return to ACQUIRE, timer cleared, no loss count; timer == i_stable_limit with all locked SHALL go to LOCKED.
REQ-024 LOCKED: o_all_locked=1 (registered, asserted first cycle in LOCKED); any lane unlocked SHALL go to ACQUIRE and increment o_loss_cnt.
REQ-025 Limit value 0 SHALL mean transition/timeout on the first cycle in the state.
REQ-026 Statistics counters SHALL saturate at all ones, never wrap; cleared only by reset.
REQ-027 o_lane_restart SHALL be zero in all cycles other than the REQ-021 timeout cycle.

Reset
REQ-028 On i_reset=0: state=IDLE, timer=0, o_lane_enable=0, o_lane_restart=0, o_all_locked=0, o_loss_cnt=0, o_restart_cnt=0, asynchronously; release synchronous to i_clock.

Configuration
REQ-029 Macro BLOCK_SYNC_SUPERVISOR_STATS_EN defined: o_loss_cnt and o_restart_cnt implemented per REQ-021/024/026.
REQ-030 Macro undefined: counters not instantiated, o_loss_cnt and o_restart_cnt tied to 0; all other behaviour identical.

Structure
REQ-031 Package pcs_sync_pkg SHALL hold state encoding constants (IDLE..LOCKED) and default NB_TIMER/NB_STAT values.
REQ-032 One sub-module sync_timer (clearable, enableable up-counter with compare-equal output, NB_TIMER wide) SHALL implement the shared timer.

Verification
REQ-033 N_LANES=4, all locks rise 5 cycles after enable, i_stable_limit=10 -> STABLE then LOCKED, o_all_locked=1 after 5+11 cycles, counters 0.
REQ-034 i_acquire_limit=20, lane 2 never locks -> o_lane_restart=4'b0100 single-cycle pulse every 21 cycles, o_restart_cnt increments each pulse.
REQ-035 In LOCKED, drop lane 0 one cycle -> ACQUIRE next cycle, o_all_locked=0, o_loss_cnt=1.
REQ-036 Lane 3 locks in same cycle as acquire timeout -> STABLE, no restart pulse, o_restart_cnt unchanged.
REQ-037 Deassert i_signal_ok in LOCKED, then assert i_reset mid-ACQUIRE -> IDLE with enables 0 next cycle; reset clears all outputs immediately.
REQ-038 NB_STAT=2, force 5 timeouts -> o_restart_cnt saturates at 3; with STATS_EN undefined both counters stay 0.

Source files
------------

// File: rtl/pcs_sync_pkg.sv
// pcs_sync_pkg: shared state encoding and default widths for the PCS block sync supervisor
package pcs_sync_pkg;
  localparam int NB_TIMER_DEF = 16;
  localparam int NB_STAT_DEF = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    STABLE  = 2'd2,
    LOCKED  = 2'd3
  } sync_state_t;
endpackage

// File: rtl/sync_timer.sv
// sync_timer: clearable, enableable up-counter with compare-equal output
// i_clock  rising-edge clock
// i_reset  asynchronous active-low reset
// i_clear  synchronous clear to zero, wins over i_enable
// i_enable count up by one
// i_limit  compare value
// o_match  count equals i_limit
module sync_timer
  import pcs_sync_pkg::*;
#(
  parameter int NB_TIMER = NB_TIMER_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic [NB_TIMER-1:0] i_limit,
  output logic                o_match
);
  logic [NB_TIMER-1:0] count;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) count <= '0;
    else if (i_clear) count <= '0;
    else if (i_enable) count <= count + 1'b1;
  end
  assign o_match = count == i_limit;
endmodule

// File: rtl/block_sync_supervisor.sv
// block_sync_supervisor: sequences per-lane block sync, restarts stuck lanes, reports stable all-lane lock
// i_clock / i_reset        rising-edge clock, asynchronous active-low reset
// i_enable, i_signal_ok    both high to run, either low forces IDLE
// i_block_lock             per-lane lock from the block sync instances
// i_acquire_limit          cycles allowed in ACQUIRE before restarting unlocked lanes
// i_stable_limit           cycles all lanes must hold lock in STABLE before LOCKED
// o_lane_enable            per-lane enable, all ones outside IDLE
// o_lane_restart           one-cycle resync pulse for lanes unlocked at acquire timeout
// o_all_locked, o_state    lock status and FSM state
// o_loss_cnt, o_restart_cnt saturating statistics, built only with BLOCK_SYNC_SUPERVISOR_STATS_EN
module block_sync_supervisor
  import pcs_sync_pkg::*;
#(
  parameter int N_LANES = 20,
  parameter int NB_TIMER = NB_TIMER_DEF,
  parameter int NB_STAT = NB_STAT_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_signal_ok,
  input  logic [N_LANES-1:0]  i_block_lock,
  input  logic [NB_TIMER-1:0] i_acquire_limit,
  input  logic [NB_TIMER-1:0] i_stable_limit,
  output logic [N_LANES-1:0]  o_lane_enable,
  output logic [N_LANES-1:0]  o_lane_restart,
  output logic                o_all_locked,
  output logic [1:0]          o_state,
  output logic [NB_STAT-1:0]  o_loss_cnt,
  output logic [NB_STAT-1:0]  o_restart_cnt
);
  sync_state_t state, state_nxt;
  logic run, all_lock, tmatch, timeout, timer_run;
  logic [NB_TIMER-1:0] limit;
  assign run = i_enable & i_signal_ok;
  assign all_lock = &i_block_lock;
  assign limit = state == STABLE ? i_stable_limit : i_acquire_limit;
  // lock completion is checked first, so a timeout coinciding with full lock never restarts
  assign timeout = run && state == ACQUIRE && !all_lock && tmatch;
  // the timer only advances while still waiting; every exit or timeout clears it
  assign timer_run = run && !tmatch && ((state == ACQUIRE && !all_lock) || (state == STABLE && all_lock));
  sync_timer #(.NB_TIMER(NB_TIMER)) u_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (!timer_run),
    .i_enable(timer_run),
    .i_limit (limit),
    .o_match (tmatch)
  );
  always_comb begin
    state_nxt = !run             ? IDLE :
                state == IDLE    ? ACQUIRE :
                state == ACQUIRE ? (all_lock ? STABLE : ACQUIRE) :
                state == STABLE  ? (!all_lock ? ACQUIRE : tmatch ? LOCKED : STABLE) :
                                   (all_lock ? LOCKED : ACQUIRE);
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      o_lane_enable  <= '0;
      o_lane_restart <= '0;
      o_all_locked   <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_lane_enable  <= {N_LANES{state_nxt != IDLE}};
      o_lane_restart <= timeout ? ~i_block_lock : '0;
      o_all_locked   <= state_nxt == LOCKED;
    end
  end
  assign o_state = state;
`ifdef BLOCK_SYNC_SUPERVISOR_STATS_EN
  logic loss;
  assign loss = run && state == LOCKED && !all_lock;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_loss_cnt    <= '0;
      o_restart_cnt <= '0;
    end else begin
      if (loss && !(&o_loss_cnt)) o_loss_cnt <= o_loss_cnt + 1'b1;
      if (timeout && !(&o_restart_cnt)) o_restart_cnt <= o_restart_cnt + 1'b1;
    end
  end
`else
  assign o_loss_cnt = '0;
  assign o_restart_cnt = '0;
`endif
endmodule

// File: tb/tb_block_sync_supervisor.sv
// tb_block_sync_supervisor: directed and random stimulus against a cycle-level reference model
module tb_block_sync_supervisor;
  localparam int NL = 4, NT = 16, NS = 2, SMAX = (1 << NS) - 1;
`ifdef BLOCK_SYNC_SUPERVISOR_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic i_clock = 1'b0, i_reset = 1'b0, i_enable = 1'b0, i_signal_ok = 1'b0;
  logic [NL-1:0] i_block_lock = '0;
  logic [NT-1:0] i_acquire_limit = '0, i_stable_limit = '0;
  logic [NL-1:0] o_lane_enable, o_lane_restart;
  logic o_all_locked;
  logic [1:0] o_state;
  logic [NS-1:0] o_loss_cnt, o_restart_cnt;
  int checks = 0, errors = 0;
  int m_st = 0, m_t = 0, m_loss = 0, m_rst = 0, cyc_n = 0;
  logic [NL-1:0] e_rs = '0;
  always #5 i_clock = ~i_clock;
  block_sync_supervisor #(.N_LANES(NL), .NB_TIMER(NT), .NB_STAT(NS)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_signal_ok    (i_signal_ok),
    .i_block_lock   (i_block_lock),
    .i_acquire_limit(i_acquire_limit),
    .i_stable_limit (i_stable_limit),
    .o_lane_enable  (o_lane_enable),
    .o_lane_restart (o_lane_restart),
    .o_all_locked   (o_all_locked),
    .o_state        (o_state),
    .o_loss_cnt     (o_loss_cnt),
    .o_restart_cnt  (o_restart_cnt)
  );
  function automatic int sat(input int v);
    return v > SMAX ? SMAX : v;
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc_n);
    end
  endtask
  task automatic check_all();
    chk("state", 8'(o_state), 8'(m_st));
    chk("lane_enable", 8'(o_lane_enable), m_st != 0 ? 8'hf : 8'h0);
    chk("lane_restart", 8'(o_lane_restart), 8'(e_rs));
    chk("all_locked", 8'(o_all_locked), 8'(m_st == 3));
    chk("loss_cnt", 8'(o_loss_cnt), 8'(m_loss * STATS));
    chk("restart_cnt", 8'(o_restart_cnt), 8'(m_rst * STATS));
  endtask
  task automatic model_reset();
    m_st = 0; m_t = 0; m_loss = 0; m_rst = 0; e_rs = '0;
  endtask
  // m_t counts cycles already spent waiting in the current ACQUIRE or STABLE attempt
  task automatic step(input logic [NL-1:0] lk, input logic en, input logic sok);
    int ns, nt;
    i_block_lock = lk; i_enable = en; i_signal_ok = sok;
    ns = m_st; nt = 0; e_rs = '0;
    if (!(en && sok)) ns = 0;
    else if (m_st == 0) ns = 1;
    else if (m_st == 1) begin
      if (&lk) ns = 2;
      else if (m_t == int'(i_acquire_limit)) begin e_rs = ~lk; m_rst = sat(m_rst + 1); end
      else nt = m_t + 1;
    end else if (m_st == 2) begin
      if (!(&lk)) ns = 1;
      else if (m_t == int'(i_stable_limit)) ns = 3;
      else nt = m_t + 1;
    end else if (!(&lk)) begin
      ns = 1; m_loss = sat(m_loss + 1);
    end
    m_st = ns; m_t = nt;
    @(posedge i_clock); #1; cyc_n++;
    check_all();
  endtask
  initial begin
    int first_lock, start, last_pulse, npulse, rst_before;
    #1;
    check_all();
    @(negedge i_clock); @(negedge i_clock);
    check_all();
    i_reset = 1'b1;
    // all lanes lock five cycles after enable, stable limit 10
    i_acquire_limit = 16'd100; i_stable_limit = 16'd10;
    start = cyc_n + 1; first_lock = -1;
    for (int i = 0; i < 5; i++) step(4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(4'hf, 1'b1, 1'b1);
      if (o_all_locked && first_lock < 0) first_lock = cyc_n;
    end
    chk("lock_latency", 8'(first_lock - start), 8'd16);
    chk("locked_state", 8'(o_state), 8'd3);
    // single-cycle drop of lane 0 while locked
    step(4'he, 1'b1, 1'b1);
    chk("drop_state", 8'(o_state), 8'd1);
    chk("drop_all_locked", 8'(o_all_locked), 8'd0);
    chk("drop_loss", 8'(o_loss_cnt), 8'(STATS));
    for (int i = 0; i < 15; i++) step(4'hf, 1'b1, 1'b1);
    step(4'hf, 1'b1, 1'b0);
    chk("sigloss_state", 8'(o_state), 8'd0);
    chk("sigloss_enable", 8'(o_lane_enable), 8'd0);
    // lane 2 never locks: periodic restart, counter saturates
    i_acquire_limit = 16'd20;
    step(4'b1011, 1'b1, 1'b1);
    last_pulse = -1; npulse = 0;
    for (int i = 0; i < 110; i++) begin
      step(4'b1011, 1'b1, 1'b1);
      if (o_lane_restart != 4'b0000) begin
        chk("pulse_pattern", 8'(o_lane_restart), 8'b0100);
        if (last_pulse >= 0) chk("pulse_spacing", 8'(cyc_n - last_pulse), 8'd21);
        last_pulse = cyc_n; npulse++;
      end
    end
    chk("pulse_count", 8'(npulse), 8'd5);
    chk("restart_sat", 8'(o_restart_cnt), 8'(3 * STATS));
    // lane 3 locks exactly on the timeout cycle
    step(4'h0, 1'b0, 1'b0);
    i_acquire_limit = 16'd3;
    step(4'b0111, 1'b1, 1'b1);
    for (int i = 0; i < 4 && m_t != 3; i++) step(4'b0111, 1'b1, 1'b1);
    rst_before = int'(o_restart_cnt);
    step(4'hf, 1'b1, 1'b1);
    chk("tie_state", 8'(o_state), 8'd2);
    chk("tie_restart", 8'(o_lane_restart), 8'd0);
    chk("tie_rcnt", 8'(o_restart_cnt), 8'(rst_before));
    // zero limits: timeout and lock on the first cycle in the state
    i_acquire_limit = '0; i_stable_limit = '0;
    step(4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0001, 1'b1, 1'b1);
    step(4'hf, 1'b1, 1'b1);
    step(4'hf, 1'b1, 1'b1);
    chk("zero_limit_locked", 8'(o_all_locked), 8'd1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        i_acquire_limit = NT'($urandom_range(0, 5));
        i_stable_limit = NT'($urandom_range(0, 5));
      end
      step($urandom_range(0, 3) == 0 ? NL'($urandom) : 4'hf,
           $urandom_range(0, 40) != 0, $urandom_range(0, 40) != 0);
    end
    // asynchronous reset in the middle of ACQUIRE
    i_acquire_limit = 16'd50;
    step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b1);
    step(4'h0, 1'b1, 1'b1);
    #2 i_reset = 1'b0;
    #1 model_reset();
    check_all();
    #3 i_reset = 1'b1;
    for (int i = 0; i < 3; i++) step(4'hf, 1'b1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
